// File: rtl/decrypt_mem_if.sv
// Memory-side bus of the RC4 decryptor: shuffled S RAM, encrypted ROM, decrypted RAM.
// Signal names match the original flat port names of decrypt_mem.
interface decrypt_mem_if;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wren;
  logic [7:0] s_q;
  logic [7:0] e_address;
  logic [7:0] e_q;
  logic [7:0] d_address;
  logic [7:0] d_data;
  logic       d_wren;

  modport master (
    output s_address, s_data, s_wren, e_address, d_address, d_data, d_wren,
    input  s_q, e_q
  );

  modport slave (
    input  s_address, s_data, s_wren, e_address, d_address, d_data, d_wren,
    output s_q, e_q
  );
endinterface

// File: rtl/decrypt_mem.sv
// RC4 PRGA decryptor: walks the shuffled S RAM, XORs the keystream into the
// encrypted ROM and writes plaintext, flagging whether it is all lowercase/space.
module decrypt_mem #(
  parameter int unsigned MSG_LEN = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  decrypt_mem_if.master mem,
  output logic          done,
  output logic          key_valid
);

  typedef enum logic [4:0] {
    IDLE, INC_I, RD_SI, WAIT_SI, SAVE_SI, CALC_J, RD_SJ, WAIT_SJ, SAVE_SJ,
    WR_I, WR_J, CALC_F, RD_F, WAIT_F, SAVE_F, WR_D, CHECK, DONE
  } state_t;

  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0] si_q, si_d, sj_q, sj_d, fidx_q, fidx_d, f_q, f_d, ev_q, ev_d;
  logic [7:0] s_addr_q, s_addr_d, s_data_q, s_data_d, e_addr_q, e_addr_d;
  logic [7:0] d_addr_q, d_addr_d, d_data_q, d_data_d;
  logic       s_wren_q, s_wren_d, d_wren_q, d_wren_d;
  logic       done_q, done_d, kv_q, kv_d;
  logic [7:0] plain;
  logic       plain_ok;

  assign plain    = f_q ^ ev_q;
  assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      fidx_q   <= '0;
      f_q      <= '0;
      ev_q     <= '0;
      s_addr_q <= '0;
      s_data_q <= '0;
      s_wren_q <= 1'b0;
      e_addr_q <= '0;
      d_addr_q <= '0;
      d_data_q <= '0;
      d_wren_q <= 1'b0;
      done_q   <= 1'b0;
      kv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      fidx_q   <= fidx_d;
      f_q      <= f_d;
      ev_q     <= ev_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      s_wren_q <= s_wren_d;
      e_addr_q <= e_addr_d;
      d_addr_q <= d_addr_d;
      d_data_q <= d_data_d;
      d_wren_q <= d_wren_d;
      done_q   <= done_d;
      kv_q     <= kv_d;
    end
  end

  // Memory controls are registered: values set up in a state appear on the
  // bus during the following cycle, so write enables pulse after WR_I/WR_J/WR_D.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    si_d     = si_q;
    sj_d     = sj_q;
    fidx_d   = fidx_q;
    f_d      = f_q;
    ev_d     = ev_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    s_wren_d = 1'b0;
    e_addr_d = e_addr_q;
    d_addr_d = d_addr_q;
    d_data_d = d_data_q;
    d_wren_d = 1'b0;
    kv_d     = kv_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = INC_I;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        kv_d    = 1'b1;
      end
      INC_I: begin
        i_d     = i_q + 8'd1;
        state_d = RD_SI;
      end
      RD_SI: begin
        s_addr_d = i_q;
        state_d  = WAIT_SI;
      end
      WAIT_SI: state_d = SAVE_SI;
      SAVE_SI: begin
        si_d    = mem.s_q;
        state_d = CALC_J;
      end
      CALC_J: begin
        j_d     = j_q + si_q;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        s_addr_d = j_q;
        state_d  = WAIT_SJ;
      end
      WAIT_SJ: state_d = SAVE_SJ;
      SAVE_SJ: begin
        sj_d    = mem.s_q;
        state_d = WR_I;
      end
      WR_I: begin
        s_addr_d = i_q;
        s_data_d = sj_q;
        s_wren_d = 1'b1;
        state_d  = WR_J;
      end
      WR_J: begin
        s_addr_d = j_q;
        s_data_d = si_q;
        s_wren_d = 1'b1;
        state_d  = CALC_F;
      end
      CALC_F: begin
        // Post-swap S[i]+S[j] equals the pre-swap sum, so the saved values suffice.
        fidx_d  = si_q + sj_q;
        state_d = RD_F;
      end
      RD_F: begin
        s_addr_d = fidx_q;
        e_addr_d = k_q;
        state_d  = WAIT_F;
      end
      WAIT_F: state_d = SAVE_F;
      SAVE_F: begin
        f_d     = mem.s_q;
        ev_d    = mem.e_q;
        state_d = WR_D;
      end
      WR_D: begin
        d_addr_d = k_q;
        d_data_d = plain;
        d_wren_d = 1'b1;
        if (!plain_ok) kv_d = 1'b0;
        state_d  = CHECK;
      end
      CHECK: begin
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = INC_I;
        end
      end
      DONE: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  assign mem.s_address = s_addr_q;
  assign mem.s_data    = s_data_q;
  assign mem.s_wren    = s_wren_q;
  assign mem.e_address = e_addr_q;
  assign mem.d_address = d_addr_q;
  assign mem.d_data    = d_data_q;
  assign mem.d_wren    = d_wren_q;
  assign done          = done_q;
  assign key_valid     = kv_q;

endmodule

// File: tb/tb_decrypt_mem.sv
// Self-checking bench for decrypt_mem: directed vector table, randomized runs
// against an array-based RC4 reference, mid-run reset and DONE hold sequences.
module tb_decrypt_mem;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic done;
  logic key_valid;

  decrypt_mem_if bus ();

  decrypt_mem #(.MSG_LEN(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mem       (bus),
    .done      (done),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem [256];
  logic [7:0] e_mem [256];
  logic [7:0] d_mem [256];
  logic [7:0] s_init [256];
  logic [7:0] ref_ks [256];
  logic [7:0] ref_d [256];
  logic [7:0] ref_s [256];
  bit         ref_kv;

  int checks = 0;
  int errors = 0;

  // Synchronous-read memories: data for an address seen at an edge appears after it.
  always @(posedge clk) begin
    bus.s_q <= s_mem[bus.s_address];
    bus.e_q <= e_mem[bus.e_address];
    if (bus.s_wren) s_mem[bus.s_address] = bus.s_data;
    if (bus.d_wren) d_mem[bus.d_address] = bus.d_data;
  end

  typedef struct {
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         kv;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_text(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
  endfunction

  // Straight RC4 PRGA over a local copy of S.
  task automatic ref_run();
    logic [7:0] s [256];
    logic [7:0] i, j, t, fi;
    for (int x = 0; x < 256; x++) s[x] = s_init[x];
    i = 8'd0;
    j = 8'd0;
    ref_kv = 1'b1;
    for (int k = 0; k < N; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i];
      s[i] = s[j];
      s[j] = t;
      fi = s[i] + s[j];
      ref_ks[k] = s[fi];
      ref_d[k] = ref_ks[k] ^ e_mem[k];
      if (!is_text(ref_d[k])) ref_kv = 1'b0;
    end
    for (int x = 0; x < 256; x++) ref_s[x] = s[x];
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic load_perm();
    logic [7:0] t;
    int r;
    load_identity();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(0, x);
      t = s_init[x];
      s_init[x] = s_init[r];
      s_init[r] = t;
    end
  endtask

  task automatic prep_mem();
    for (int x = 0; x < 256; x++) begin
      s_mem[x] = s_init[x];
      d_mem[x] = 8'h00;
    end
  endtask

  task automatic craft_letters();
    ref_run();
    for (int k = 0; k < N; k++) e_mem[k] = ref_ks[k] ^ (8'h61 + 8'(k % 26));
  endtask

  task automatic run_case(input string tag, input bit toggle, input bit check_id);
    int cyc, sp, dp, dbad, sbad;
    bit got;
    ref_run();
    prep_mem();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    cyc = 0; sp = 0; dp = 0; got = 1'b0;
    while (cyc < 2000 && !got) begin
      start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (bus.s_wren) sp++;
      if (bus.d_wren) dp++;
      if (check_id && bus.d_wren && bus.d_address == 8'd1) begin
        chk({tag, " S[2] after byte1"}, 32'(s_mem[2]), 32'h03);
        chk({tag, " S[3] after byte1"}, 32'(s_mem[3]), 32'h02);
      end
      if (done) got = 1'b1;
    end
    chk({tag, " cycles to done"}, 32'(cyc), 32'(16 * N));
    chk({tag, " s_wren pulses"}, 32'(sp), 32'(2 * N));
    chk({tag, " d_wren pulses"}, 32'(dp), 32'(N));
    chk({tag, " key_valid"}, 32'(key_valid), 32'(ref_kv));
    dbad = 0;
    sbad = 0;
    for (int k = 0; k < N; k++) if (d_mem[k] !== ref_d[k]) dbad++;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) sbad++;
    chk({tag, " D bytes wrong"}, 32'(dbad), 32'd0);
    chk({tag, " S bytes wrong"}, 32'(sbad), 32'd0);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk({tag, " done held"}, 32'(done), 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " done drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    for (int x = 0; x < 256; x++) begin
      s_mem[x] = 8'h00;
      e_mem[x] = 8'h00;
      d_mem[x] = 8'h00;
    end
    vecs[0] = '{e0: 8'h63, e1: 8'h67, d0: 8'h61, d1: 8'h62, kv: 1'b1};
    vecs[1] = '{e0: 8'h00, e1: 8'h67, d0: 8'h02, d1: 8'h62, kv: 1'b0};
    vecs[2] = '{e0: 8'h22, e1: 8'h67, d0: 8'h20, d1: 8'h62, kv: 1'b1};
    vecs[3] = '{e0: 8'h78, e1: 8'h7E, d0: 8'h7A, d1: 8'h7B, kv: 1'b0};
    vecs[4] = '{e0: 8'h63, e1: 8'h65, d0: 8'h61, d1: 8'h60, kv: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset addr/data", {bus.s_address, bus.s_data, bus.e_address, bus.d_address}, 32'h0);
    chk("reset flags", {bus.d_data, done, key_valid, bus.s_wren, bus.d_wren}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 5; v++) begin
      load_identity();
      craft_letters();
      e_mem[0] = vecs[v].e0;
      e_mem[1] = vecs[v].e1;
      run_case($sformatf("vec%0d", v), 1'b0, 1'b1);
      chk($sformatf("vec%0d D0", v), 32'(d_mem[0]), 32'(vecs[v].d0));
      chk($sformatf("vec%0d D1", v), 32'(d_mem[1]), 32'(vecs[v].d1));
      chk($sformatf("vec%0d kv table", v), 32'(key_valid), 32'(vecs[v].kv));
    end

    for (int r = 0; r < 4; r++) begin
      load_perm();
      for (int k = 0; k < 256; k++) e_mem[k] = 8'($urandom);
      run_case($sformatf("rand%0d", r), 1'b1, 1'b0);
    end
    load_perm();
    craft_letters();
    run_case("rand_text", 1'b1, 1'b0);

    // Reset in WAIT_SJ of byte 5, then a clean restart from a reloaded S.
    begin
      int cyc;
      int act;
      load_perm();
      craft_letters();
      prep_mem();
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (cyc < 16 * 5 + 6) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("pre-reset key_valid", 32'(key_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("midrun reset addr/data", {bus.s_address, bus.s_data, bus.e_address, bus.d_address}, 32'h0);
      chk("midrun reset flags", {bus.d_data, done, key_valid, bus.s_wren, bus.d_wren}, 32'h0);
      @(negedge clk) reset_n = 1'b1;
      act = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (bus.s_wren || bus.d_wren || done) act++;
      end
      chk("idle after reset release", 32'(act), 32'd0);
      run_case("after_reset", 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
